// File: rtl/interrupt_responder_pkg.sv
// Shared types and helpers for the interrupt responder: FSM state encoding,
// vector width, line index type and the vector address calculation.
package intresp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CLEAR   = 2'd2,
    SERVICE = 2'd3
  } state_t;

  localparam int VECTOR_WIDTH = 16;

  typedef logic [3:0] idx_t;

  // Handler address for a line; wraps modulo 2**VECTOR_WIDTH.
  function automatic logic [VECTOR_WIDTH-1:0] calc_vector(
    input logic [VECTOR_WIDTH-1:0] base,
    input int                      stride,
    input idx_t                    idx
  );
    logic [31:0] full;
    full = 32'(base) + (32'(idx) * 32'(stride));
    return full[VECTOR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/interrupt_responder_if.sv
// Signal bundle between the interrupt controller / CPU and the responder.
// master = responder side, slave = controller/CPU side.
interface interrupt_responder_if
  import intresp_pkg::*;
#(
  parameter int NUM_INPUTS = 1
);

  logic                    int_in;
  logic [NUM_INPUTS-1:0]   active_in;
  logic [NUM_INPUTS-1:0]   active_out;
  logic                    active_out_write;
  logic                    ie;
  logic                    boundary;
  logic                    irq_req;
  logic                    irq_ack;
  logic [VECTOR_WIDTH-1:0] vector;
  logic                    in_service;
  logic                    reti;

  modport master (
    input  int_in, active_in, ie, boundary, irq_ack, reti,
    output active_out, active_out_write, irq_req, vector, in_service
  );

  modport slave (
    output int_in, active_in, ie, boundary, irq_ack, reti,
    input  active_out, active_out_write, irq_req, vector, in_service
  );

endinterface

// File: rtl/interrupt_responder_priority_picker.sv
// Combinational circular find-first-set: first set request bit at or above
// start, wrapping from NUM_INPUTS-1 back to 0. start must be < NUM_INPUTS.
module priority_picker
  import intresp_pkg::*;
#(
  parameter int NUM_INPUTS = 1
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  idx_t                  start,
  output logic                  found,
  output idx_t                  idx
);

  logic hit_s;

  // Search in rotated order; hit_s fires only for the first set bit.
  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        hit_s = !found && req[j] && (((int'(start) + k) % NUM_INPUTS) == j);
        found = found | hit_s;
        idx   = hit_s ? idx_t'(j) : idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_responder.sv
// CPU-side interrupt responder: select a pending line, hand its vector to the
// CPU, clear it in the controller, track service until reti.
// Optional macro INTRESP_ROUND_ROBIN_EN enables rotating-priority selection.
module interrupt_responder
  import intresp_pkg::*;
#(
  parameter int                      NUM_INPUTS    = 1,
  parameter logic [VECTOR_WIDTH-1:0] VECTOR_BASE   = 16'h0020,
  parameter int                      VECTOR_STRIDE = 4
) (
  input logic                   clk,
  input logic                   reset,
  interrupt_responder_if.master bus
);

  state_t                  state_q, state_d;
  idx_t                    idx_q, idx_d;
  logic [VECTOR_WIDTH-1:0] vector_q, vector_d;
  logic                    irq_req_q, irq_req_d;
  logic                    in_service_q, in_service_d;
  logic                    write_q, write_d;
  logic [NUM_INPUTS-1:0]   clear_mask_s;
  logic                    pick_found_s;
  idx_t                    pick_idx_s;
  idx_t                    pick_start_s;

`ifdef INTRESP_ROUND_ROBIN_EN
  idx_t rr_q, rr_d;
  assign pick_start_s = rr_q;
`else
  assign pick_start_s = 4'd0;
`endif

  priority_picker #(.NUM_INPUTS(NUM_INPUTS)) u_picker (
    .req   (bus.active_in),
    .start (pick_start_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vector_d = vector_q;
`ifdef INTRESP_ROUND_ROBIN_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.int_in && bus.ie && bus.boundary && (bus.active_in != '0) && pick_found_s) begin
          state_d  = REQ;
          idx_d    = pick_idx_s;
          vector_d = calc_vector(VECTOR_BASE, VECTOR_STRIDE, pick_idx_s);
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_d = CLEAR;
`ifdef INTRESP_ROUND_ROBIN_EN
          rr_d = (idx_q == idx_t'(NUM_INPUTS - 1)) ? 4'd0 : idx_q + 4'd1;
`endif
        end else begin
          state_d = REQ;
        end
      end
      CLEAR:   state_d = SERVICE;
      SERVICE: begin
        if (bus.reti) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: state_d = IDLE;
    endcase
    irq_req_d    = (state_d == REQ);
    in_service_d = (state_d == SERVICE);
    write_d      = (state_d == CLEAR);
  end

  // State, held index, vector and decoded output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      vector_q     <= VECTOR_BASE;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      write_q      <= 1'b0;
`ifdef INTRESP_ROUND_ROBIN_EN
      rr_q         <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vector_q     <= vector_d;
      irq_req_q    <= irq_req_d;
      in_service_q <= in_service_d;
      write_q      <= write_d;
`ifdef INTRESP_ROUND_ROBIN_EN
      rr_q         <= rr_d;
`endif
    end
  end

  // Write-back uses the live active_in so bits raised after selection survive.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      clear_mask_s[i] = (idx_q == idx_t'(i));
    end
    if (write_q) begin
      bus.active_out = bus.active_in & ~clear_mask_s;
    end else begin
      bus.active_out = '0;
    end
  end

  assign bus.active_out_write = write_q;
  assign bus.irq_req          = irq_req_q;
  assign bus.in_service       = in_service_q;
  assign bus.vector           = vector_q;

endmodule

// File: tb/tb_interrupt_responder.sv
// Bench for interrupt_responder (NUM_INPUTS=4): directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_interrupt_responder;

  localparam int N = 4;
  localparam int PH_WAIT = 0, PH_ASK = 1, PH_CLR = 2, PH_RUN = 3;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  interrupt_responder_if #(.NUM_INPUTS(N)) bus ();

  interrupt_responder #(
    .NUM_INPUTS(N), .VECTOR_BASE(16'h0020), .VECTOR_STRIDE(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which phase of the interrupt transaction we are in.
  int          phase = PH_WAIT;
  int          line  = 0;
  int          rr    = 0;
  logic [15:0] m_vec = 16'h0020;
  bit          known = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_line(input logic [3:0] act, input int start);
    for (int off = 0; off < N; off++) begin
      int cand;
      cand = (start + off) % N;
      if (act[cand]) return cand;
    end
    return 0;
  endfunction

  task automatic compare_model();
    logic [3:0] one;
    logic [3:0] exp_ao;
    one    = 4'b0001;
    exp_ao = (phase == PH_CLR) ? (bus.active_in & ~(one << line)) : 4'b0000;
    check_val("irq_req",    bus.irq_req,          phase == PH_ASK);
    check_val("in_service", bus.in_service,       phase == PH_RUN);
    check_val("aout_write", bus.active_out_write, phase == PH_CLR);
    check_val("active_out", bus.active_out,       exp_ao);
    check_val("vector",     bus.vector,           m_vec);
  endtask

  task automatic model_update(input logic rst, input logic irq, input logic [3:0] act,
                              input logic en, input logic bnd, input logic ack, input logic rt);
    if (rst) begin
      phase = PH_WAIT; line = 0; rr = 0; m_vec = 16'h0020; known = 1'b1;
    end else if (phase == PH_WAIT) begin
      if (irq && en && bnd && act != 4'b0000) begin
        line  = pick_line(act, rr);
        m_vec = 16'h0020 + 16'(line * 4);
        phase = PH_ASK;
      end
    end else if (phase == PH_ASK) begin
      if (ack) begin
        phase = PH_CLR;
`ifdef INTRESP_ROUND_ROBIN_EN
        rr = (line + 1) % N;
`endif
      end
    end else if (phase == PH_CLR) begin
      phase = PH_RUN;
    end else if (rt) begin
      phase = PH_WAIT;
    end
  endtask

  // One clock: drive at negedge, compare, then advance the model at posedge.
  task automatic step(input logic rst, input logic irq, input logic [3:0] act,
                      input logic en, input logic bnd, input logic ack, input logic rt);
    @(negedge clk);
    reset = rst; bus.int_in = irq; bus.active_in = act; bus.ie = en;
    bus.boundary = bnd; bus.irq_ack = ack; bus.reti = rt;
    #1;
    if (known) compare_model();
    @(posedge clk);
    model_update(rst, irq, act, en, bnd, ack, rt);
    #1;
  endtask

  task automatic idle_step(input logic [3:0] act);
    step(1'b0, |act, act, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic qualify(input logic [3:0] act);
    step(1'b0, 1'b1, act, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  logic [15:0] rr_exp [3];

  initial begin
    reset = 1'b1; bus.int_in = 1'b0; bus.active_in = 4'b0000; bus.ie = 1'b0;
    bus.boundary = 1'b0; bus.irq_ack = 1'b0; bus.reti = 1'b0;
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_vector", bus.vector, 16'h0020);
    check_val("rst_req", bus.irq_req, 1'b0);

    // Basic request / clear / service.
    qualify(4'b0110);
    check_val("tp_req", bus.irq_req, 1'b1);
    check_val("tp_vec", bus.vector, 16'h0024);
    step(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("tp_wr", bus.active_out_write, 1'b1);
    check_val("tp_aout", bus.active_out, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      idle_step(4'b0100);
      check_val("tp_svc", bus.in_service, 1'b1);
    end
    step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("tp_reti", bus.in_service, 1'b0);

    // Gating by ie and by boundary.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("gate_ie", bus.irq_req, 1'b0);
      step(1'b0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
      check_val("gate_bnd", bus.irq_req, 1'b0);
    end

    // Request held with ie/boundary low; late arrival preserved on clear.
    qualify(4'b0010);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("hold_req", bus.irq_req, 1'b1);
    end
    step(1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("late_aout", bus.active_out, 4'b1000);
    idle_step(4'b1000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in REQ, then stale ack.
    qualify(4'b0100);
    step(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rstreq_req", bus.irq_req, 1'b0);
    check_val("rstreq_vec", bus.vector, 16'h0020);
    step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("stale_ack", bus.active_out_write, 1'b0);

    // Reset in SERVICE, then stale reti.
    qualify(4'b1000);
    step(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_step(4'b0000);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rstsvc_svc", bus.in_service, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("stale_reti", bus.irq_req, 1'b0);

    // Three services with 1001 pending.
`ifdef INTRESP_ROUND_ROBIN_EN
    rr_exp[0] = 16'h0020; rr_exp[1] = 16'h002C; rr_exp[2] = 16'h0020;
`else
    rr_exp[0] = 16'h0020; rr_exp[1] = 16'h0020; rr_exp[2] = 16'h0020;
`endif
    for (int s = 0; s < 3; s++) begin
      qualify(4'b1001);
      check_val("svc_vec", bus.vector, rr_exp[s]);
      step(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0);
      idle_step(4'b1001);
      if (s < 2) step(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Back-to-back: reti with a qualifying request in the same cycle.
    step(1'b0, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("b2b_first", bus.irq_req, 1'b0);
    qualify(4'b1001);
    check_val("b2b_second", bus.irq_req, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] act;
      logic       irq;
      act = ($urandom_range(3) == 0) ? 4'b0000 : 4'($urandom_range(15));
      irq = ($urandom_range(9) == 0) ? 1'($urandom_range(1)) : |act;
      step(($urandom_range(99) == 0), irq, act,
           ($urandom_range(4) != 0), ($urandom_range(9) < 6),
           ($urandom_range(9) < 3), ($urandom_range(9) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_responder.md
Name: interrupt_responder

Overview:
- CPU-side counterpart to the interrupt controller; consumes the controller's int_out and active_out, and drives its active_in / active_in_write back.
- At an instruction boundary with interrupts globally enabled, selects one pending line and presents its vector to the CPU through a req/ack handshake.
- Clears the selected active bit in the controller, then tracks the in-service period until return-from-interrupt.

Parameters:
- NUM_INPUTS, 1, number of interrupt lines; legal range 1..16; must match the controller instance.
- VECTOR_BASE, 16'h0020, vector address of line 0.
- VECTOR_STRIDE, 4, address distance between consecutive line vectors.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- int_in  input  1  controller int_out (OR of active bits)
- active_in  input  NUM_INPUTS  controller active_out (pending bits)
- active_out  output  NUM_INPUTS  value written back to controller active_in
- active_out_write  output  1  controller active_in_write strobe
- ie  input  1  CPU global interrupt enable
- boundary  input  1  CPU at instruction boundary this cycle
- irq_req  output  1  interrupt request to CPU
- irq_ack  input  1  CPU accepts vector
- vector  output  16  handler address, VECTOR_BASE + idx*VECTOR_STRIDE, truncated to 16 bits
- in_service  output  1  handler running
- reti  input  1  one-cycle pulse, handler returned

Behaviour:
- States: IDLE, REQ, CLEAR, SERVICE. Reset, from any state, forces IDLE: irq_req=0, active_out_write=0, in_service=0, vector=VECTOR_BASE, held idx=0. Reset mid-handshake abandons the request silently.
- IDLE: if int_in & ie & boundary & (active_in != 0), latch idx = selected line and register vector, then go to REQ. irq_req is 1 in the cycle after the qualifying edge (latency 1).
- REQ: irq_req=1; vector holds stable. On irq_ack, go to CLEAR. Deasserting ie or boundary does not withdraw the request; irq_req is held until ack. If software clears the active bit while in REQ, the request still completes (spurious vector is tolerated).
- CLEAR: exactly one cycle. active_out_write=1. active_out = active_in & ~(1<<idx), computed combinationally from the current active_in so bits set since selection are preserved. The controller's own OR-in of new inputs in the same cycle still wins. Then go to SERVICE.
- SERVICE: in_service=1; no new selection. On reti, go to IDLE. A new request can be raised no earlier than 1 cycle after IDLE re-entry.
- Inputs ignored outside their state: irq_ack outside REQ, reti outside SERVICE.
- active_out = 0 whenever active_out_write = 0.
- Selection (default): fixed priority, lowest set bit wins (bit 0 highest).
- NUM_INPUTS=1: idx is always 0.

Optional Feature:
- Macro: INTRESP_ROUND_ROBIN_EN.
- Defined:
  - A pointer register rr (reset value 0) gives the starting bit for the search. The search is circular: first set bit at or above rr, wrapping past NUM_INPUTS-1 to 0.
  - On the REQ->CLEAR transition, rr = (idx+1) mod NUM_INPUTS.
- Undefined: no rr register; fixed priority as above.

Decomposition:
- Package intresp_pkg: state enum typedef (IDLE, REQ, CLEAR, SERVICE), VECTOR_WIDTH=16, and an index typedef of 4 bits.
- One sub-module, priority_picker: combinational circular find-first-set.
  - Inputs: request vector, start pointer.
  - Outputs: found flag, index.
  - Tied to start=0 when round robin is compiled out.

Test Plan:
- NUM_INPUTS=4, active_in=4'b0110, int_in=1, ie=1, boundary=1:
  - irq_req=1 next cycle, vector=16'h0024.
  - After irq_ack: one cycle with active_out_write=1 and active_out=4'b0100.
  - Then in_service=1 until reti.
- Gating: ie=0 or boundary=0 with pending bits -> irq_req stays 0 indefinitely. Dropping ie while in REQ -> irq_req remains 1 until ack.
- Late arrival: active_in goes 4'b0010 -> 4'b1010 during REQ -> in CLEAR, active_out=4'b1000.
- Reset asserted in REQ and in SERVICE -> next cycle all outputs at reset values, state IDLE. A stale irq_ack or reti afterwards has no effect.
- Round robin (INTRESP_ROUND_ROBIN_EN defined), active_in held 4'b1001 across three services:
  - Served lines are 0, 3, 0; vectors 16'h0020, 16'h002C, 16'h0020.
  - Without the macro: lines 0, 0, 0.
- Back-to-back: reti and a qualifying request in the same cycle -> irq_req rises no earlier than 2 cycles after the reti cycle.
